pe_cfg_loader: RTL

//   Writer side of the PE control interface.
//   - Accepts a 4-bit nibble configuration stream over a valid/ready handshake.
//   - Assembles one 8-bit control word per PE and holds it in shadow registers

---
 rtl/pe_cfg_pkg.sv | 37 +++
 rtl/pe_cfg_loader.sv | 103 ++++++++++
 2 files changed

// File: rtl/pe_cfg_pkg.sv
// Shared definitions for the PE config loader: widths, FSM states and PE control word fields.
// Used by the RTL and by the bench when it builds control words.
package pe_cfg_pkg;

    localparam int CTRL_W = 8;
    localparam int NIB_W  = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_HI = 3'd1,
        LOAD_LO = 3'd2,
        COMMIT  = 3'd3,
        RUN     = 3'd4
    } cfg_state_t;

    // PE control word layout: SEL_OP0=[7:5], SEL_OP1=[4:2], ALU_OP=[1:0]
    localparam int ALU_OP_LSB  = 0;
    localparam int ALU_OP_W    = 2;
    localparam int SEL_OP1_LSB = 2;
    localparam int SEL_OP1_W   = 3;
    localparam int SEL_OP0_LSB = 5;
    localparam int SEL_OP0_W   = 3;

    function automatic logic [CTRL_W-1:0] pack_ctrl(
        input logic [SEL_OP0_W-1:0] sel_op0,
        input logic [SEL_OP1_W-1:0] sel_op1,
        input logic [ALU_OP_W-1:0]  alu_op
    );
        logic [CTRL_W-1:0] w;
        w = '0;
        w[SEL_OP0_LSB +: SEL_OP0_W] = sel_op0;
        w[SEL_OP1_LSB +: SEL_OP1_W] = sel_op1;
        w[ALU_OP_LSB  +: ALU_OP_W]  = alu_op;
        return w;
    endfunction

endpackage

// File: rtl/pe_cfg_loader.sv
// Assembles nibble stream into per-PE control words held in shadow registers; sequences PE enables.
// Latency: first handshake one cycle after start; commit strobe 2*NUM_PE+1 cycles after start. cfg_ready only in load states.
module pe_cfg_loader
    import pe_cfg_pkg::*;
#(
    parameter int NUM_PE = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     cfg_valid,
    input  logic [NIB_W-1:0]         cfg_data,
    output logic                     cfg_ready,
    input  logic                     step,
    output logic [NUM_PE*CTRL_W-1:0] ctrl_out,
    output logic [NUM_PE-1:0]        pe_en,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

    cfg_state_t        state_q,  state_d;
    logic [IDX_W-1:0]  pe_idx_q, pe_idx_d;
    logic [NIB_W-1:0]  hi_buf_q, hi_buf_d;
    logic [CTRL_W-1:0] shadow_q [NUM_PE];
    logic [CTRL_W-1:0] shadow_d [NUM_PE];
    logic              xfer;

    always_comb begin
        cfg_ready = (state_q == LOAD_HI) || (state_q == LOAD_LO);
        busy      = cfg_ready || (state_q == COMMIT);
        done      = (state_q == COMMIT);
        xfer      = cfg_valid & cfg_ready;
        pe_en     = '0;
        if (state_q == COMMIT) begin
            pe_en = '1;
        end else if (state_q == RUN && step && !start) begin
            // a restart wins over step so PEs never latch during a reload
            pe_en = '1;
        end
    end

    always_comb begin
        state_d  = state_q;
        pe_idx_d = pe_idx_q;
        hi_buf_d = hi_buf_q;
        for (int i = 0; i < NUM_PE; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    state_d  = LOAD_HI;
                    pe_idx_d = '0;
                end
            end
            LOAD_HI: begin
                if (xfer) begin
                    hi_buf_d = cfg_data;
                    state_d  = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (xfer) begin
                    shadow_d[pe_idx_q] = {hi_buf_q, cfg_data};
                    if (pe_idx_q == LAST_IDX) begin
                        state_d = COMMIT;
                    end else begin
                        pe_idx_d = pe_idx_q + 1'b1;
                        state_d  = LOAD_HI;
                    end
                end
            end
            COMMIT:  state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pe_idx_q <= '0;
            hi_buf_q <= '0;
            for (int i = 0; i < NUM_PE; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pe_idx_q <= pe_idx_d;
            hi_buf_q <= hi_buf_d;
            for (int i = 0; i < NUM_PE; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_PE; g++) begin : g_ctrl
        assign ctrl_out[g*CTRL_W +: CTRL_W] = shadow_q[g];
    end

endmodule
